// File: rtl/temp_avg_tenths_pkg.sv
// Shared types and constants for the temperature averaging / tenths-scaling path.
package temp_avg_tenths_pkg;

  localparam int TEMP_W    = 13;
  localparam int FRAC_BITS = 4;
  localparam int TENTHS_W  = 16;
  localparam int SCALE_MUL = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    PEND
  } state_t;

endpackage

// File: rtl/temp_moving_avg.sv
// Moving average over 2^LOG2_N signed samples; the first sample prefills the window.
// Updates one cycle after upd; avg is combinational from the running sum (floors toward -inf).
module temp_moving_avg
  import temp_avg_tenths_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd,
  input  logic signed [TEMP_W-1:0] sample,
  output logic signed [TEMP_W-1:0] avg,
  output logic                     filled
);

  localparam int N     = 1 << LOG2_N;
  localparam int IDX_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int SUM_W = TEMP_W + LOG2_N;

  logic signed [TEMP_W-1:0] win [N];
  logic [IDX_W-1:0]         idx;
  logic signed [SUM_W-1:0]  sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      idx    <= '0;
      sum    <= '0;
      filled <= 1'b0;
    end else if (upd) begin
      if (!filled) begin
        // Seed the whole window so the first result is the sample itself.
        for (int i = 0; i < N; i++) win[i] <= sample;
        sum    <= SUM_W'(sample) <<< LOG2_N;
        filled <= 1'b1;
      end else begin
        win[idx] <= sample;
        sum      <= sum - SUM_W'(win[idx]) + SUM_W'(sample);
        idx      <= (LOG2_N == 0) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Taking the upper bits of the sum is the arithmetic shift right by LOG2_N.
  assign avg = sum[LOG2_N +: TEMP_W];

endmodule

// File: rtl/temp_avg_tenths.sv
// Sensor sample capture, moving average, tenths-of-degree scaling and BCD trigger handshake.
// Trigger 3 cycles after the rdy_in edge; held in PEND while conv_idle is low (a newer sample replaces the result).
module temp_avg_tenths
  import temp_avg_tenths_pkg::*;
#(
  parameter int LOG2_N = 3,
  parameter bit ROUND  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TEMP_W-1:0]   temp_in,
  input  logic                rdy_in,
  input  logic                err_in,
  input  logic                conv_idle,
  output logic                conv_trigger,
  output logic [TENTHS_W-1:0] tenths,
  output logic                negative,
  output logic                err_o,
  output logic                filled
);

  state_t state, state_nxt;

  logic                     rdy_d;
  logic                     cap_evt;
  logic                     accepting;
  logic                     take;
  logic                     upd;
  logic                     load;
  logic                     pending;
  logic signed [TEMP_W-1:0] sample_q;
  logic signed [TEMP_W-1:0] avg;
  logic [TEMP_W-1:0]        mag;
  logic [TENTHS_W-1:0]      t_scaled;
  logic [TENTHS_W-1:0]      tenths_nxt;
  logic                     neg_nxt;

  assign cap_evt   = rdy_in & ~rdy_d;
  assign accepting = (state == IDLE) || (state == PEND);
  assign take      = cap_evt & accepting & ~err_in;

  temp_moving_avg #(
    .LOG2_N(LOG2_N)
  ) u_avg (
    .clk   (clk),
    .reset (reset),
    .upd   (upd),
    .sample(sample_q),
    .avg   (avg),
    .filled(filled)
  );

  // |avg| * 10 / 16 with optional half-LSB rounding; |avg| tops out at 4096.
  assign mag        = avg[TEMP_W-1] ? -avg : avg;
  assign t_scaled   = TENTHS_W'(mag) * TENTHS_W'(SCALE_MUL)
                    + (ROUND ? TENTHS_W'(1 << (FRAC_BITS - 1)) : '0);
  assign tenths_nxt = t_scaled >> FRAC_BITS;
  assign neg_nxt    = avg[TEMP_W-1] && (tenths_nxt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rdy_d    <= 1'b0;
      err_o    <= 1'b0;
      sample_q <= '0;
      tenths   <= '0;
      negative <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_d <= rdy_in;
      if (cap_evt && accepting) err_o <= err_in;
      if (take) sample_q <= temp_in;
      if (load) begin
        tenths   <= tenths_nxt;
        negative <= neg_nxt;
        pending  <= 1'b1;
      end else if (conv_trigger) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    upd          = 1'b0;
    load         = 1'b0;
    conv_trigger = 1'b0;
    case (state)
      IDLE:  if (take) state_nxt = ACCUM;
      ACCUM: begin
        upd       = 1'b1;
        state_nxt = SCALE;
      end
      SCALE: begin
        load      = 1'b1;
        state_nxt = PEND;
      end
      PEND: begin
        // A fresh sample supersedes the unsent result rather than queueing a second trigger.
        if (take) begin
          state_nxt = ACCUM;
        end else if (conv_idle && pending) begin
          conv_trigger = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_cap_state: assert property (@(posedge clk) disable iff (reset) cap_evt |-> accepting);

endmodule

// File: doc/temp_avg_tenths.md
Name: temp_avg_tenths

Overview:
Post-processing stage between the I2C temperature sensor controller and the binary-to-BCD converter.
- Captures each new 13-bit two's-complement reading (LSB = 1/16 °C) and keeps a moving average over 2^LOG2_N samples.
- Converts the average to sign plus magnitude in tenths of °C, rounded.
- Triggers the BCD converter through its trigger/idle handshake.

Parameters:
- LOG2_N, 3, log2 of averaging window length. Legal range 0..5; 0 means no averaging.
- ROUND, 1, 1 = round half up on the tenths conversion; 0 = truncate.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- temp_in  in  13  sensor reading, two's complement, 1/16 °C per LSB
- rdy_in  in  1  sensor data-ready; a new sample is valid on its rising edge
- err_in  in  1  sensor communication error, level
- conv_idle  in  1  BCD converter idle; 1 = a new conversion may be started
- conv_trigger  out  1  one-cycle pulse that starts the BCD conversion
- tenths  out  16  |average| × 10 / 16, unsigned; zero-extended from 12 bits
- negative  out  1  sign of the average; never 1 when tenths == 0
- err_o  out  1  1 while the most recent capture attempt was rejected because of an error
- filled  out  1  window holds ≥1 real sample (set by the first accepted sample)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation). All outputs are 0.
  - Buffer, sum, index, pending flag and rdy_d are cleared; state = IDLE.
- Capture: in cycle C, the condition rdy_in & ~rdy_d is registered as a capture event.
  - If err_in = 1 in cycle C, the sample is discarded and err_o <= 1. Buffer and outputs are unchanged.
  - Otherwise err_o <= 0 and the sample goes to ACCUM.
- Buffer: 2^LOG2_N entries of 13 bits with a write index that wraps modulo 2^LOG2_N.
  - Running sum is signed, 13+LOG2_N bits.
- First sample after reset (filled = 0): every entry is prefilled with the sample and sum = sample <<< LOG2_N. filled <= 1.
- Later samples: sum <= sum − buf[idx] + sample; buf[idx] <= sample; idx <= idx+1 (wraps).
- Average: avg = sum >>> LOG2_N. This is an arithmetic shift and floors toward −∞.
- Scale:
  - mag = |avg| (max 4096).
  - t = mag×10 + (ROUND ? 8 : 0).
  - tenths_next = t >> 4 (max 2560).
  - negative_next = avg < 0 and tenths_next ≠ 0.
- FSM:
  - IDLE: on a capture event → ACCUM.
  - ACCUM (1 cycle): buffer/sum update → SCALE.
  - SCALE (1 cycle): tenths/negative registered, pending <= 1 → PEND.
  - PEND: when conv_idle = 1, conv_trigger = 1 for exactly one cycle, pending <= 0 → IDLE. Otherwise stay.
- Latency: the trigger is asserted 3 cycles after cycle C (cycle C+3) when conv_idle is already 1.
- New capture in PEND: it is accepted. The FSM goes ACCUM → SCALE and tenths/negative are overwritten (latest value wins).
  - Exactly one trigger is issued for a pending result; no trigger is queued up.
- tenths/negative change only in SCALE. They are stable while conv_trigger is high and during the conversion, unless a new sample arrives.
- A capture event in ACCUM or SCALE cannot occur, because the sensor sample rate is much slower than the clock. If one does, it is dropped. Assertion: no capture event outside IDLE/PEND.
- Only the rising edge of rdy_in counts. A held-high rdy_in yields one capture.

Decomposition:
- Shared package holds:
  - FSM state enumeration (IDLE, ACCUM, SCALE, PEND).
  - Constants TEMP_W = 13, FRAC_BITS = 4, TENTHS_W = 16, SCALE_MUL = 10.
- One sub-module: temp_moving_avg. It contains the buffer, index, running sum, prefill logic and the avg output.
- The top file contains edge detect, error gating, scaling and the handshake FSM.

Test Plan:
- Reset; temp_in = 0x0190 (25.0 °C) with an rdy_in rising edge; conv_idle = 1 → filled = 1, tenths = 250, negative = 0, conv_trigger is a single pulse at C+3.
- Prefill at 0x0190, then 8 samples of 0x01A0 (26 °C), LOG2_N = 3 → successive tenths 251, 253, 254, 255, 256, 258, 259, 260. Trigger after each sample.
- Negative: first sample 0x1F60 (−10 °C) → tenths = 100, negative = 1. Then 0x1FFF (−1/16 °C) with LOG2_N = 0 → avg −1, tenths = 1 (ROUND = 1), negative = 1. With ROUND = 0 → tenths = 0, negative = 0.
- Back-pressure: conv_idle = 0; samples 0x0190 then 0x0200 at LOG2_N = 0 → no trigger while idle is low. When idle rises: one pulse, tenths = 320.
- Error: err_in = 1 at the rdy_in edge → err_o = 1, no trigger, sum unchanged. The next clean sample clears err_o and produces a trigger.
- reset asserted in PEND → conv_trigger never pulses, all outputs are 0 immediately. The next sample is treated as a first (prefill) sample.
